// File: rtl/serial_paralelo_c_if.sv
// Serial link bundle: 1-bit stream in, framed byte and status out.
interface serial_paralelo_c_if;
   logic       data_in;
   logic [7:0] data_out;
   logic       valid_out;
   logic       active_out;
   logic       byte_strobe;

   modport master (
      output data_in,
      input  data_out,
      input  valid_out,
      input  active_out,
      input  byte_strobe
   );

   modport slave (
      input  data_in,
      output data_out,
      output valid_out,
      output active_out,
      output byte_strobe
   );
endinterface

// File: rtl/serial_paralelo_c.sv
// Serial-to-parallel receiver on clk_32f: aligns on IDLE_SYM, goes
// active after BC_REQ framed idles, then emits each non-idle byte.
module serial_paralelo_c #(
   parameter logic [7:0]  IDLE_SYM = 8'hBC,
   parameter int unsigned BC_REQ   = 4
) (
   input  logic                clk_32f,
   input  logic                reset,
   serial_paralelo_c_if.slave  bus
);

   localparam logic [3:0] BC_REQ_L = 4'(BC_REQ);

   typedef enum logic [1:0] {
      S_SEARCH  = 2'd0,
      S_ALIGNED = 2'd1,
      S_ACTIVE  = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state;
   logic [7:0] r_sr;
   logic [7:0] w_nxt;
   logic [2:0] r_bit_cnt;
   logic [2:0] w_bit_cnt;
   logic [2:0] r_bc_cnt;
   logic [2:0] w_bc_cnt;
   logic [7:0] r_data;
   logic [7:0] w_data;
   logic       r_valid;
   logic       w_valid;
   logic       r_active;
   logic       w_active;
   logic       r_strobe;
   logic       w_strobe;

   logic       w_idle;
   logic       w_byte_end;
   logic [3:0] w_bc_inc;
   logic [2:0] w_bc_sat;
   logic       w_bc_done;

   assign w_nxt      = {r_sr[6:0], bus.data_in};
   assign w_idle     = (w_nxt == IDLE_SYM);
   assign w_byte_end = (r_bit_cnt == 3'd7);
   assign w_bc_inc   = {1'b0, r_bc_cnt} + 4'd1;
   assign w_bc_done  = (w_bc_inc >= BC_REQ_L);
   assign w_bc_sat   = w_bc_done ? BC_REQ_L[2:0]
                                 : w_bc_inc[2:0];

   always_comb begin
      w_state   = r_state;
      w_bit_cnt = r_bit_cnt + 3'd1;
      w_bc_cnt  = r_bc_cnt;
      w_data    = r_data;
      w_valid   = r_valid;
      w_active  = r_active;
      w_strobe  = 1'b0;
      unique case (r_state)
         S_SEARCH: begin
            // Unframed: every edge is a candidate boundary.
            w_bit_cnt = 3'd0;
            if (w_idle) begin
               w_bc_cnt = 3'd1;
               if (BC_REQ_L == 4'd1) begin
                  w_state  = S_ACTIVE;
                  w_active = 1'b1;
               end else begin
                  w_state  = S_ALIGNED;
               end
            end
         end
         S_ALIGNED: begin
            w_strobe = w_byte_end;
            if (w_byte_end) begin
               if (w_idle) begin
                  w_bc_cnt = w_bc_sat;
                  if (w_bc_done) begin
                     w_state  = S_ACTIVE;
                     w_active = 1'b1;
                  end
               end else begin
                  w_bc_cnt = 3'd0;
                  w_state  = S_SEARCH;
               end
            end
         end
         S_ACTIVE: begin
            w_strobe = w_byte_end;
            if (w_byte_end) begin
               if (w_idle) begin
                  w_valid = 1'b0;
               end else begin
                  w_data  = w_nxt;
                  w_valid = 1'b1;
               end
            end
         end
         default: begin
            w_state = S_SEARCH;
         end
      endcase
   end

   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         r_state   <= S_SEARCH;
         r_sr      <= 8'h00;
         r_bit_cnt <= 3'd0;
         r_bc_cnt  <= 3'd0;
         r_data    <= 8'h00;
         r_valid   <= 1'b0;
         r_active  <= 1'b0;
         r_strobe  <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_sr      <= w_nxt;
         r_bit_cnt <= w_bit_cnt;
         r_bc_cnt  <= w_bc_cnt;
         r_data    <= w_data;
         r_valid   <= w_valid;
         r_active  <= w_active;
         r_strobe  <= w_strobe;
      end
   end

   assign bus.data_out    = r_data;
   assign bus.valid_out   = r_valid;
   assign bus.active_out  = r_active;
   assign bus.byte_strobe = r_strobe;

endmodule

// File: doc/serial_paralelo_c.md
# serial_paralelo_c

Serial-to-parallel receiver on the 32f clock domain, downstream of the clock generator and of the serial link. It recovers byte alignment from the idle symbol (0xBC) on a 1-bit MSB-first stream and declares the link active after a run of consecutive idle symbols. Once active, it presents each non-idle byte as an 8-bit word with a valid flag, updated once per 8 `clk_32f` cycles (one 4f period).

## Interface
Parameters:
- `IDLE_SYM`, 8'hBC: comma/idle symbol used for alignment and for marking "no data".
- `BC_REQ`, 4: consecutive aligned idle symbols required to enter ACTIVE. Legal range 1..7.

Ports:
- `clk_32f`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low reset. 0 = reset asserted.
- `data_in`  in  1: serial data, MSB first, one bit per `clk_32f` cycle.
- `data_out`  out  8: last received non-idle byte.
- `valid_out`  out  1: 1 while `data_out` holds a byte received in ACTIVE and the latest byte was non-idle.
- `active_out`  out  1: 1 once the link is active.
- `byte_strobe`  out  1: one-cycle pulse on each aligned byte boundary.

## Operation
- Internal state: 8-bit shift register `sr`, 3-bit bit counter `bit_cnt`, 3-bit idle counter `bc_cnt`, and an FSM with states SEARCH, ALIGNED and ACTIVE.
- Assembled value at each edge: `nxt = {sr[6:0], data_in}`. `sr <= nxt` on every edge in every state.
- **SEARCH** (reset state):
  - Evaluates every edge with no byte framing. `byte_strobe` is held at 0.
  - If `nxt == IDLE_SYM`: `bit_cnt <= 0`, `bc_cnt <= 1`, go to ALIGNED. If `BC_REQ == 1`, go directly to ACTIVE.
- **ALIGNED**:
  - `bit_cnt` increments each edge and wraps 7 -> 0.
  - At the edge where `bit_cnt == 7` (byte complete), `byte_strobe` pulses.
  - If `nxt == IDLE_SYM`: `bc_cnt <= bc_cnt + 1`. When `bc_cnt + 1 == BC_REQ`, go to ACTIVE and set `active_out <= 1` on the same edge.
  - If `nxt != IDLE_SYM`: `bc_cnt <= 0` and return to SEARCH. `data_out` and `valid_out` are unchanged.
- **ACTIVE**:
  - Framing continues exactly as in ALIGNED.
  - At byte complete with `nxt != IDLE_SYM`: `data_out <= nxt`, `valid_out <= 1`.
  - At byte complete with `nxt == IDLE_SYM`: `valid_out <= 0`, `data_out` holds its previous value.
  - ACTIVE is left only by reset. Misalignment is not re-checked.
- `bc_cnt` saturates at `BC_REQ` and never wraps.

## Timing
- Reset values, applied asynchronously: `data_out` = 8'h00, `valid_out` = 0, `active_out` = 0, `byte_strobe` = 0, `sr` = 0, `bit_cnt` = 0, `bc_cnt` = 0, FSM = SEARCH.
- Deasserting reset takes effect at the next rising edge. The first edge after deassert samples bit 0 of the stream.
- Latency: outputs change on the same edge that samples the last (LSB) bit of a byte. They are visible in the following cycle and stable for 8 cycles.
- `byte_strobe` is high for exactly 1 cycle per 8 while in ALIGNED or ACTIVE.
- Alignment edge: the edge on which the first `IDLE_SYM` completes. The next byte boundary is 8 edges later.
- `active_out` rises on the edge completing the `BC_REQ`-th consecutive idle symbol. It does not rise on an earlier edge and does not glitch.
- Reset asserted mid-byte or in ACTIVE clears all outputs immediately, with no dependence on the clock. Any partial byte is discarded.
- `IDLE_SYM` appearing at a bit offset other than the frame boundary in ALIGNED or ACTIVE is ignored. Only framed bytes count.

## Test plan
- Reset, then 4× 0xBC MSB-first from the first edge -> `active_out` rises on edge 32, `valid_out` = 0, `data_out` = 0x00, `byte_strobe` on edges 16, 24 and 32.
- After active, send 0x5A then 0xBC -> `data_out` = 0x5A with `valid_out` = 1 after edge 40. After edge 48, `valid_out` = 0 and `data_out` stays 0x5A.
- Send 3 junk bits (1,0,1), then 4× 0xBC -> alignment occurs on the edge completing the first 0xBC (edge 11), and `active_out` rises at edge 35.
- Send 0xBC, 0xBC, 0x00, 0xBC -> returns to SEARCH at edge 24 and realigns at edge 32. `active_out` stays 0 throughout, with `bc_cnt` = 1.
- In ACTIVE, stream 0x01, 0xFF, 0x80 -> `data_out` updates every 8 edges with `valid_out` held at 1. Assert `reset` = 0 mid-byte -> all outputs read 0 before the next clock edge.
- With `BC_REQ` = 1: a single 0xBC -> `active_out` = 1 on its completing edge.
